// File: rtl/fpdiv_iter_execute.sv
// rtl/fpdiv_iter_execute.sv - restoring mantissa divider, one quotient bit per cycle
// Optional feature macro: FPDIV_DIV0_DETECT_EN (early divide-by-zero exit with dz flag)
module fpdiv_iter_execute #(
   parameter int MW = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [MW-1:0] Ma,
   input  logic [MW-1:0] Mb,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [MW+1:0] Mq,
   output logic          sticky,
   output logic          dz
);

   localparam int CW = $clog2(MW + 2);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          r_state;
   logic [MW-1:0]   r_b;
   logic [MW:0]     r_r;
   logic [CW-1:0]   r_cnt;
   logic [MW+1:0]   r_q;
   logic            r_sticky;
   logic            r_dz;
   logic            r_in_ready;
   logic            r_out_valid;

   logic            w_accept;
   logic            w_ge;
   logic [MW:0]     w_r_sub;
   logic [MW:0]     w_r_next;
   logic            w_last;
   logic            w_div0;
   logic            w_acc_dz;

   assign w_accept = in_valid && r_in_ready;

   // Restoring step: subtract the divisor when it fits, then shift left.
   // R stays below 2*Mb, so MW+1 bits never overflow for normalized divisors.
   assign w_ge     = (r_r >= {1'b0, r_b});
   assign w_r_sub  = w_ge ? (r_r - {1'b0, r_b}) : r_r;
   assign w_r_next = {w_r_sub[MW-1:0], 1'b0};
   assign w_last   = (r_cnt == '0);

`ifdef FPDIV_DIV0_DETECT_EN
   assign w_acc_dz = (Mb == '0);
   assign w_div0   = r_dz;
`else
   assign w_acc_dz = 1'b0;
   assign w_div0   = 1'b0;
`endif

   // Control FSM plus datapath registers; all outputs come straight from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_b         <= '0;
         r_r         <= '0;
         r_cnt       <= '0;
         r_q         <= '0;
         r_sticky    <= 1'b0;
         r_dz        <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_b        <= Mb;
                  r_r        <= {1'b0, Ma};
                  r_q        <= '0;
                  r_sticky   <= 1'b0;
                  r_dz       <= w_acc_dz;
                  r_cnt      <= w_acc_dz ? '0 : CW'(MW + 1);
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               if (w_div0) begin
                  // Zero divisor short-circuits to the saturated quotient.
                  r_q         <= '1;
                  r_r         <= '0;
                  r_sticky    <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  // Quotient bits arrive MSB first, so shifting them in lands
                  // each one at bit position r_cnt.
                  r_q <= {r_q[MW:0], w_ge};
                  r_r <= w_r_next;
                  if (w_last) begin
                     r_sticky    <= (w_r_next != '0);
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign Mq        = r_q;
   assign sticky    = r_sticky;
   assign dz        = r_dz;

endmodule

// File: tb/tb_fpdiv_iter_execute.sv
// tb/tb_fpdiv_iter_execute.sv - self-checking bench for fpdiv_iter_execute
module tb_fpdiv_iter_execute;

   localparam int MW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [MW-1:0] Ma;
   logic [MW-1:0] Mb;
   logic          out_valid;
   logic          out_ready;
   logic [MW+1:0] Mq;
   logic          sticky;
   logic          dz;

   int n_pass  = 0;
   int n_total = 0;

   logic [MW+1:0] exp_q;
   logic          exp_s;
   logic          exp_dz;

`ifdef FPDIV_DIV0_DETECT_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   fpdiv_iter_execute #(.MW(MW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .Ma(Ma), .Mb(Mb), .out_valid(out_valid), .out_ready(out_ready),
      .Mq(Mq), .sticky(sticky), .dz(dz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   // Reference: exact integer quotient of Ma*2^(MW+1) by Mb; zero divisor saturates.
   task automatic model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                        output logic [MW+1:0] q, output logic s, output logic d,
                        output int lat);
      logic [2*MW+1:0] num;
      logic [2*MW+1:0] den;
      logic [2*MW+1:0] quo;
      num = {{(MW+1){1'b0}}, a} << (MW + 1);
      den = {{(MW+2){1'b0}}, b};
      if (b == '0) begin
         q   = '1;
         s   = 1'b0;
         d   = DZ_EN;
         lat = DZ_EN ? 1 : MW + 2;
      end else begin
         quo = num / den;
         q   = quo[MW+1:0];
         s   = ((num % den) != '0);
         d   = 1'b0;
         lat = MW + 2;
      end
   endtask

   // Compare process: whenever a result is presented, it must match the model.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         chk("mq", 64'(Mq), 64'(exp_q));
         chk("sticky", 64'(sticky), 64'(exp_s));
         chk("dz", 64'(dz), 64'(exp_dz));
         chk("in_ready_while_valid", 64'(in_ready), 64'd0);
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_wait", 64'(in_ready), 64'd1);
   endtask

   // One operation: accept, measure latency, hold the result, hand it off.
   task automatic run_op(input logic [MW-1:0] a, input logic [MW-1:0] b, input int hold,
                         input bit use_lit, input logic [MW+1:0] lit_q, input logic lit_s);
      int lat;
      int exp_lat;
      logic [MW+1:0] mq_m;
      logic s_m;
      logic d_m;
      model(a, b, mq_m, s_m, d_m, exp_lat);
      if (use_lit) begin
         chk("model_pin_q", 64'(mq_m), 64'(lit_q));
         chk("model_pin_s", 64'(s_m), 64'(lit_s));
      end
      exp_q  = mq_m;
      exp_s  = s_m;
      exp_dz = d_m;
      wait_ready();
      Ma = a;
      Mb = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      Ma = MW'($urandom);
      Mb = MW'($urandom);
      chk("in_ready_after_accept", 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'(exp_lat));
      for (int h = 0; h < hold; h++) begin
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      Ma = MW'($urandom) | {1'b1, {(MW-1){1'b0}}};
      Mb = MW'($urandom) | {1'b1, {(MW-1){1'b0}}};
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("handoff_valid", 64'(out_valid), 64'd0);
      chk("handoff_in_ready", 64'(in_ready), 64'd1);
      chk("idle_keeps_mq", 64'(Mq), 64'(exp_q));
      chk("idle_keeps_sticky", 64'(sticky), 64'(exp_s));
      in_valid = 1'b0;
   endtask

   initial begin
      int seen;
      logic [MW-1:0] ra;
      logic [MW-1:0] rb;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      Ma = '0;
      Mb = '0;
      exp_q = '0;
      exp_s = 1'b0;
      exp_dz = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mq", 64'(Mq), 64'd0);
      chk("rst_sticky", 64'(sticky), 64'd0);
      chk("rst_dz", 64'(dz), 64'd0);

      run_op(24'h800000, 24'h800000, 0, 1'b1, 26'h2000000, 1'b0);
      run_op(24'hFFFFFF, 24'h800000, 1, 1'b1, 26'h3FFFFFC, 1'b0);
      run_op(24'h800000, 24'hC00000, 5, 1'b1, 26'h1555555, 1'b1);
      run_op(24'hABCDEF, 24'h000000, 2, 1'b1, 26'h3FFFFFF, 1'b0);

      // Reset in the middle of an iteration run.
      wait_ready();
      Ma = 24'h912345;
      Mb = 24'hA00001;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_mq", 64'(Mq), 64'd0);
      seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("midrst_no_result", 64'(seen), 64'd0);
      run_op(24'h800000, 24'h800000, 0, 1'b1, 26'h2000000, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra = MW'($urandom) | {1'b1, {(MW-1){1'b0}}};
         rb = MW'($urandom) | {1'b1, {(MW-1){1'b0}}};
         if (i % 8 == 0) rb = ra;
         run_op(ra, rb, int'($urandom_range(0, 3)), 1'b0, '0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fpdiv_iter_execute.md
FPDIV_ITER_EXECUTE -- requirements
Module: fpdiv_iter_execute

Interface
REQ-001 SHALL have parameter MW, default 24, the mantissa width including the hidden bit; the quotient width is MW+2.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  an operand pair is presented.
REQ-005 SHALL have port in_ready  output  1  the block can accept operands.
REQ-006 SHALL have port Ma  input  MW  dividend mantissa (A), normalized, hidden bit in the MSB.
REQ-007 SHALL have port Mb  input  MW  divisor mantissa (B), normalized, hidden bit in the MSB.
REQ-008 SHALL have port out_valid  output  1  the result is available.
REQ-009 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-010 SHALL have port Mq  output  MW+2  quotient, equal to floor(Ma*2^(MW+1)/Mb).
REQ-011 SHALL have port sticky  output  1  the final remainder is nonzero.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE: IDLE->RUN on accept; RUN->DONE after MW+2 iterations; DONE->IDLE when out_valid and out_ready are both high.
REQ-014 SHALL drive in_ready high only in IDLE; an accept occurs on an edge where in_valid and in_ready are both high.
REQ-015 SHALL, on accept, register Ma and Mb, load the remainder R (MW+1 bits) with Ma, clear Mq, and load the iteration counter with MW+1.
REQ-016 SHALL perform one restoring iteration per RUN cycle, MSB first: if R>=Mb then set quotient bit[count] to 1 and R=R-Mb, else set it to 0; then R=R<<1 and decrement the counter.
REQ-017 SHALL enter DONE on the edge that computes quotient bit 0; out_valid is high exactly MW+2 edges after the accept edge (26 for MW=24).
REQ-018 SHALL set sticky to 1 in DONE if and only if the final R is nonzero.
REQ-019 SHALL hold Mq, sticky, dz and out_valid stable in DONE while out_ready is low.
REQ-020 SHALL ignore in_valid in RUN and DONE; an operand pair offered in the handoff cycle is accepted no earlier than the next cycle, once the block is in IDLE.
REQ-021 SHALL keep Mq, sticky and dz at their last values in IDLE, with out_valid low.
REQ-022 SHALL give a result in [2^(MW), 2^(MW+2)) for normalized operands; operand checking is the caller's job.

Reset
REQ-023 SHALL, when rst is high at an edge, force state IDLE, in_ready=1, out_valid=0, Mq=0, sticky=0, dz=0, counter=0 and R=0.
REQ-024 SHALL treat rst as overriding in_valid and out_ready in the same cycle.
REQ-025 SHALL, on reset mid-RUN or in DONE, discard the in-flight operation and produce no result.

Configuration
REQ-026 SHALL, when FPDIV_DIV0_DETECT_EN is defined, detect Mb==0 on accept and go directly to DONE with Mq=all ones, sticky=0 and dz=1; out_valid is high 1 edge after accept.
REQ-027 SHALL, without FPDIV_DIV0_DETECT_EN, tie dz to 0 and run Mb==0 through the normal iteration, giving Mq=all ones and sticky=0 after MW+2 cycles.

Verification
REQ-028 SHALL cover: Ma=0x800000, Mb=0x800000 -> Mq=0x2000000, sticky=0, out_valid 26 edges after accept.
REQ-029 SHALL cover: Ma=0xFFFFFF, Mb=0x800000 -> Mq=0x3FFFFFC, sticky=0.
REQ-030 SHALL cover: Ma=0x800000, Mb=0xC00000 -> Mq=0x1555555, sticky=1.
REQ-031 SHALL cover: out_ready held low 5 cycles after out_valid -> Mq, sticky and out_valid stable for all 5 cycles, in_ready=0 throughout; in_ready=1 on the cycle after the handoff.
REQ-032 SHALL cover: rst asserted at iteration 10 -> next cycle out_valid=0, in_ready=1, Mq=0; a following op Ma=Mb=0x800000 -> Mq=0x2000000.
REQ-033 SHALL cover: Mb=0 with the macro defined -> dz=1, Mq=0x3FFFFFF, out_valid 1 edge after accept; Mb=0 without the macro -> dz=0, Mq=0x3FFFFFF after 26 edges.
